alu_muldiv: RTL and testbench

- Multi-cycle RV32M multiply/divide unit, parametrised in data width; sits beside the single-cycle ALU in the execute stage.
- Decodes the same funct7/funct3 fields as the ALU and accepts ops over a valid/ready handshake.
- Iterates one bit per cycle (shift-add multiply, restoring divide) and holds the result until the consumer takes it.
- Flush input lets the pipeline abort an in-flight op on a branch or trap.

---
 rtl/alu_muldiv.sv | 195 +++++++++++++++++++
 tb/tb_alu_muldiv.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Takes one op over a valid/ready handshake, iterates one bit per cycle
// (shift-add multiply, restoring divide) and holds the result until the
// consumer takes it. Divide-by-zero, signed overflow and illegal funct7
// bypass the iteration and answer on the accept edge.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] source1,
    input  logic [XLEN-1:0] source2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [XLEN-1:0]     b_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [XLEN-1:0]     result_q;
    logic                out_valid_q;
    logic                illegal_q;

    // Operand decode at accept time
    logic                a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                neg_d;
    logic                special_d, spec_ill_d;
    logic [XLEN-1:0]     spec_res_d;
    logic                div_zero, div_ovf;

    // Iteration datapath
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift, div_diff;
    logic [2*XLEN-1:0]   acc_step_d;
    logic [2*XLEN-1:0]   prod_fin;
    logic [XLEN-1:0]     quo_fin, rem_fin, result_fin_d;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign illegal   = illegal_q;

    // Decode operand signedness, magnitudes, output sign and the early-out cases
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        neg_d    = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010: begin
                a_signed = 1'b1;
            end
            default: begin
                a_signed = 1'b0;
                b_signed = 1'b0;
            end
        endcase
        a_neg = a_signed & source1[XLEN-1];
        b_neg = b_signed & source2[XLEN-1];
        a_mag = a_neg ? (~source1 + {{(XLEN-1){1'b0}}, 1'b1}) : source1;
        b_mag = b_neg ? (~source2 + {{(XLEN-1){1'b0}}, 1'b1}) : source2;
        // Quotient and high product follow both signs; remainder and MULHSU follow rs1 only
        case (funct3)
            3'b001, 3'b100: neg_d = a_neg ^ b_neg;
            3'b010, 3'b110: neg_d = a_neg;
            default:        neg_d = 1'b0;
        endcase
        div_zero = (source2 == {XLEN{1'b0}});
        div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                   (source1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (source2 == {XLEN{1'b1}});
        special_d  = 1'b1;
        spec_ill_d = 1'b0;
        spec_res_d = {XLEN{1'b0}};
        if (funct7 != 7'b000_0001) begin
            spec_ill_d = 1'b1;
        end else if (funct3[2] && div_zero) begin
            spec_res_d = funct3[1] ? source1 : {XLEN{1'b1}};
        end else if (div_ovf) begin
            spec_res_d = funct3[1] ? {XLEN{1'b0}} : source1;
        end else begin
            special_d = 1'b0;
        end
    end

    // One multiply or divide step on the shared accumulator, plus result fix-up
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, b_q};
        if (op_q[2]) begin
            // Restoring divide: high half is the partial remainder, low half collects quotient bits
            acc_step_d = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                          acc_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            // Shift-add multiply: multiplier drains out of the low half as product bits shift in
            acc_step_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod_fin = neg_q ? (~acc_step_d + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_step_d;
        quo_fin  = neg_q ? (~acc_step_d[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                         : acc_step_d[XLEN-1:0];
        rem_fin  = neg_q ? (~acc_step_d[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1})
                         : acc_step_d[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 result_fin_d = prod_fin[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_fin_d = prod_fin[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_fin_d = quo_fin;
            3'b110, 3'b111:         result_fin_d = rem_fin;
            default:                result_fin_d = {XLEN{1'b0}};
        endcase
    end

    // Control FSM with registered result, valid and illegal flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'b000;
            neg_q       <= 1'b0;
            b_q         <= {XLEN{1'b0}};
            acc_q       <= {(2*XLEN){1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            result_q    <= {XLEN{1'b0}};
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q  <= funct3;
                        neg_q <= neg_d;
                        b_q   <= b_mag;
                        acc_q <= {{XLEN{1'b0}}, a_mag};
                        cnt_q <= {CNT_W{1'b0}};
                        if (special_d) begin
                            result_q    <= spec_res_d;
                            illegal_q   <= spec_ill_d;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    acc_q <= acc_step_d;
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        result_q    <= result_fin_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        illegal_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors with hand-computed results for alu_muldiv,
// plus hand-written sequences for backpressure, flush and async reset.
`timescale 1ns/1ps
module tb_alu_muldiv;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] source1;
    logic [31:0] source2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    alu_muldiv #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct7(funct7), .funct3(funct3),
        .source1(source1), .source2(source2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_ill;
        int          exp_lat;  // clock edges after the accept edge until out_valid is seen
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ei, input int el);
        vec_t v;
        v.name = nm; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b;
        v.exp_res = er; v.exp_ill = ei; v.exp_lat = el;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one op, wait (bounded) for its result, then take it with a one-cycle out_ready.
    // lat = edges after the accept edge before out_valid is seen (0 = right after accept).
    task automatic run_op(input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ill, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clock); #1; w++;
        end
        funct7 = f7; funct3 = f3; source1 = a; source2 = b; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        // scramble inputs: the unit must have latched them on the accept edge
        source1 = ~a; source2 = ~b; funct3 = f3 ^ 3'b101; funct7 = 7'b111_1111;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1; lat++;
        end
        if (!out_valid) begin
            tests++; fails++;
            $display("FAIL timeout: out_valid never rose (got 0 expected 1)");
        end
        res = result;
        ill = illegal;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        il;
        int          lt;
        bit          seen;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        funct7 = 7'd0; funct3 = 3'd0; source1 = 32'd0; source2 = 32'd0;

        add("mul_7_m3",   7'h01, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 32);
        add("mulh_min",   7'h01, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 32);
        add("mulhsu_min", 7'h01, 3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, 1'b0, 32);
        add("mulhu_min",  7'h01, 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 32);
        add("mul_min",    7'h01, 3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 32);
        add("mulh_m1m1",  7'h01, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32);
        add("mulhu_m1m1", 7'h01, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 32);
        add("div_m7_2",   7'h01, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 32);
        add("rem_m7_2",   7'h01, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 32);
        add("divu_big_2", 7'h01, 3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 1'b0, 32);
        add("remu_big_2", 7'h01, 3'b111, 32'hFFFFFFF9, 32'd2,        32'h00000001, 1'b0, 32);
        add("div_7_m2",   7'h01, 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32);
        add("rem_7_m2",   7'h01, 3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0, 32);
        add("divu_5_0",   7'h01, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 0);
        add("rem_5_0",    7'h01, 3'b110, 32'd5,        32'd0,        32'h00000005, 1'b0, 0);
        add("div_ovf",    7'h01, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 0);
        add("rem_ovf",    7'h01, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 0);
        add("illegal_f7", 7'h20, 3'b000, 32'd3,        32'd4,        32'h00000000, 1'b1, 0);

        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result",    result,             32'd0);
        chk("rst_illegal",   {31'd0, illegal},   32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        reset = 1'b0;
        @(posedge clock); #1;

        // table-driven vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b, r, il, lt);
            chk({vecs[i].name, "_result"},  r,          vecs[i].exp_res);
            chk({vecs[i].name, "_illegal"}, {31'd0, il}, {31'd0, vecs[i].exp_ill});
            chk({vecs[i].name, "_latency"}, lt,         vecs[i].exp_lat);
        end

        // backpressure: 5*6 held for 5 cycles, then handshake and immediate next op
        funct7 = 7'h01; funct3 = 3'b000; source1 = 32'd5; source2 = 32'd6; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lt = 0;
        while (!out_valid && lt < 100) begin
            @(posedge clock); #1; lt++;
        end
        chk("bp_latency", lt, 32'd32);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result",    result,             32'd30);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("bp_hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_hs_in_ready",  {31'd0, in_ready},  32'd1);
        chk("bp_hs_result_kept", result, 32'd30);
        run_op(7'h01, 3'b101, 32'd100, 32'd7, r, il, lt);
        chk("bp_next_divu", r, 32'd14);
        chk("bp_next_lat",  lt, 32'd32);

        // flush on the 10th busy cycle, then recover
        funct7 = 7'h01; funct3 = 3'b000; source1 = 32'd9; source2 = 32'd9; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", {31'd0, seen}, 32'd0);
        run_op(7'h01, 3'b000, 32'd3, 32'd4, r, il, lt);
        chk("flush_recover_mul", r, 32'd12);

        // async reset mid-busy
        funct7 = 7'h01; funct3 = 3'b000; source1 = 32'd5; source2 = 32'd5; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_result",    result,             32'd0);
        chk("arst_illegal",   {31'd0, illegal},   32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("arst_no_result", {31'd0, seen}, 32'd0);
        run_op(7'h01, 3'b110, 32'hFFFFFF9C, 32'd7, r, il, lt);
        chk("arst_recover_rem", r, 32'hFFFFFFFE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
